// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and default width for the multiply/divide unit
package mdu_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mdu_state_e;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 shift-add multiply or restoring-divide iteration
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand & {WIDTH{acc[0]}}};
    shifted  = acc[2*WIDTH-1:WIDTH-1];
    diff     = shifted - {1'b0, operand};
    q_bit    = is_div & ~diff[WIDTH];
    acc_next = is_div ? {q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0], acc[WIDTH-2:0], q_bit}
                      : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit with HI/LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_next, prod;
  logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, rs_mag, rt_mag, quo, rem;
  logic               div_q, div_d, neg_q, neg_d, negr_q, negr_d, dz_q, dz_d, fix_q, fix_d;
  logic               q_bit, is_md, sgn;
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (div_q),
    .acc     (acc_q),
    .operand (opnd_q),
    .acc_next(acc_next),
    .q_bit   (q_bit)
  );
  assign is_md  = op <= MDU_DIVU;
  assign sgn    = (op == MDU_MULT) || (op == MDU_DIV);
  assign rs_mag = (sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag = (sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  assign prod   = neg_q ? -acc_q : acc_q;
  assign quo    = (neg_q && !dz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem    = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    fix_d   = fix_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == RUN) begin
      if (fix_q) begin
        hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d    = div_q ? quo : prod[WIDTH-1:0];
        fix_d   = 1'b0;
        state_d = FIN;
      end else begin
        acc_d = acc_next;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        fix_d = cnt_q == '0;
      end
    end else begin
      state_d = IDLE;
      if (start && is_md) begin
        div_d   = op[1];
        opnd_d  = op[1] ? rt_mag : rs_mag;
        acc_d   = {{WIDTH{1'b0}}, op[1] ? rs_mag : rt_mag};
        neg_d   = sgn && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
        negr_d  = sgn && rs_val[WIDTH-1];
        dz_d    = op[1] && (rt_val == '0);
        cnt_d   = CW'(WIDTH - 1);
        fix_d   = 1'b0;
        state_d = RUN;
      end
      hi_d = (start && op == MDU_MTHI) ? rs_val : hi_d;
      lo_d = (start && op == MDU_MTLO) ? rs_val : lo_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      fix_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      fix_q   <= fix_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == FIN;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS core.
- Sits beside the ALU, downstream of the register file. It consumes the rs/rt read data and the decoded op, and produces HI/LO for mfhi/mflo writeback.
- Multi-cycle: it holds busy so the control path can stall subsequent mult/div/mfhi/mflo instructions.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a rising edge when busy=0.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- rs_val  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- rt_val  input  WIDTH  multiplier / divisor.
- busy  output  1  operation in progress; new starts are ignored.
- done  output  1  one-cycle pulse when HI/LO hold a new mult/div result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter=0.
- Reset asserted mid-operation aborts it. No done pulse is produced and HI/LO are cleared.
- States:
  - IDLE: waiting for a request.
  - RUN: performing iterations.
  - FIN: a single cycle with done=1.
- IDLE/FIN, start=1, op=MULT..DIVU:
  - Latch operands. Signed ops store magnitudes and record the result signs: product sign = rs^rt; quotient sign = rs^rt; remainder sign = rs.
  - Load counter=WIDTH-1 and go to RUN.
- IDLE/FIN, start=1, op=MTHI/MTLO:
  - Write hi (or lo) = rs_val at that edge.
  - Stay or return to IDLE. busy is never raised and done is not pulsed.
- IDLE/FIN, op 6/7, or start=0: go to IDLE; HI/LO unchanged.
- RUN, multiply: radix-2 shift-add, one multiplier bit per cycle, using a 2*WIDTH-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, using a WIDTH+1-bit partial remainder.
- RUN, counter=0: the next edge applies sign correction (two's-complement negate), writes HI/LO, and enters FIN.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product.
- Divide result: lo = quotient (truncated toward zero), hi = remainder (same sign as dividend).
- Latency: for a start sampled at edge N, busy=1 for exactly WIDTH+1 cycles, from after edge N up to edge N+WIDTH+1. done=1 and the new hi/lo are visible in the cycle after edge N+WIDTH+1.
- Back-to-back: start is accepted in the FIN cycle, so the next operation begins with no idle gap.
- start while busy=1: ignored entirely, including MTHI/MTLO. No queueing.
- Divide by zero: no trap, same latency. Result is hi=rs_val (unmodified), lo={WIDTH{1'b1}} for both DIV and DIVU.
- Signed overflow, DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0. No exception.
- Operands and op are ignored after acceptance. Input changes during RUN have no effect.
- HI/LO hold their value at all times except on a mult/div completion edge or an accepted MTHI/MTLO edge.

Decomposition:
- Package mdu_pkg:
  - op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - state encodings: IDLE, RUN, FIN.
  - the WIDTH default.
- One sub-module, mdu_step: purely combinational single-iteration step.
  - Inputs: mode (mul/div), accumulator/remainder, operand.
  - Outputs: the next accumulator/remainder and quotient bit.
- The top level holds the FSM, counter, sign flags and the HI/LO registers.

Test Plan:
- MULT, rs=0xFFFFFFFD (-3), rt=5 → after 33 busy cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU, rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Checks that busy is high exactly 33 cycles and done is high exactly 1 cycle.
- DIV, rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then, in the FIN cycle, start DIVU rs=100, rt=7 → lo=14, hi=2, with no gap cycle.
- DIVU, rs=7, rt=0 → hi=7, lo=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 → both registers update one edge after each request; busy=0 and done=0 throughout.
- MULT start, then:
  - at cycle 10, start MTLO → ignored;
  - at cycle 20, assert rst for 1 cycle → busy=0, done never pulses, hi=lo=0;
  - the next MULTU 2*3 → lo=6, hi=0.
